// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative signed multiply/divide unit for the multicycle MIPS datapath.
//   Multiplication is shift-add and division is restoring; both retire one
//   bit per clock. Magnitudes are processed and the sign is fixed up in a
//   final step. The unit owns the Hi/Lo result registers.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high; aborts any operation, clears outputs
//   start      : operation request, sampled only while idle
//   op         : 0 = mult, 1 = div (sampled with start)
//   a, b       : two's-complement operands (dividend/divisor for div)
//   busy       : high whenever the sequencer is not idle
//   done       : one-cycle pulse, hi/lo hold the new result in that cycle
//   hilo_write : same as done, write strobe for the Hi/Lo select mux
//   div_zero   : one-cycle pulse when a div is requested with b == 0
//   hi, lo     : mult -> {upper, lower} product; div -> {remainder, quotient}
module muldiv_sequencer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic              hilo_write,
   output logic              div_zero,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE,
      S_DZ
   } state_t;

   state_t              state_q;
   logic                op_q;
   logic                neg_q;     // product / quotient must be negated
   logic                rsign_q;   // remainder takes the sign of a
   logic [DATA_W-1:0]   opnd_q;    // multiplicand (mult) or divisor (div) magnitude
   logic [2*DATA_W-1:0] acc_q;     // mult: {partial product, multiplier}; div: {remainder, quotient}
   logic [2*DATA_W-1:0] acc_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   hi_q, lo_q;
   logic                busy_q, done_q, dz_q;

   logic [DATA_W:0]     msum;
   logic [DATA_W:0]     rshift;
   logic [DATA_W:0]     rdiff;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix, rem_fix;

   // Unsigned magnitude; the most negative value maps to 2^(DATA_W-1).
   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
      return x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
   endfunction

   // One iteration of the shared accumulator.
   always_comb begin
      acc_d  = acc_q;
      msum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
      rshift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
      rdiff  = rshift - {1'b0, opnd_q};
      if (!op_q) begin
         // Carry out of the add lands in the top bit after the shift.
         if (acc_q[0])
            acc_d = {msum, acc_q[DATA_W-1:1]};
         else
            acc_d = {1'b0, acc_q[2*DATA_W-1:1]};
      end else begin
         // Restoring step: keep the difference only if it did not go negative.
         if (rshift >= {1'b0, opnd_q})
            acc_d = {rdiff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
         else
            acc_d = {rshift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
      end
   end

   // Sign fix-up of the magnitude result.
   always_comb begin
      prod_fix = neg_q   ? -acc_q : acc_q;
      quo_fix  = neg_q   ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
      rem_fix  = rsign_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
         neg_q   <= 1'b0;
         rsign_q <= 1'b0;
         opnd_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               dz_q   <= 1'b0;
               if (start) begin
                  busy_q <= 1'b1;
                  if (op && (b == '0)) begin
                     dz_q    <= 1'b1;
                     state_q <= S_DZ;
                  end else begin
                     op_q    <= op;
                     neg_q   <= a[DATA_W-1] ^ b[DATA_W-1];
                     rsign_q <= a[DATA_W-1];
                     opnd_q  <= op ? mag(b) : mag(a);
                     acc_q   <= {{DATA_W{1'b0}}, (op ? mag(a) : mag(b))};
                     cnt_q   <= '0;
                     state_q <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DATA_W - 1))
                  state_q <= S_FIX;
            end
            S_FIX: begin
               if (!op_q) begin
                  hi_q <= prod_fix[2*DATA_W-1:DATA_W];
                  lo_q <= prod_fix[DATA_W-1:0];
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            S_DZ: begin
               dz_q    <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               dz_q    <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign hilo_write = done_q;
   assign div_zero   = dz_q;
   assign hi         = hi_q;
   assign lo         = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed testbench for muldiv_sequencer with hand-computed results.
module tb_muldiv_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        hilo_write;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_sequencer #(.DATA_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .hilo_write (hilo_write),
      .div_zero   (div_zero),
      .hi         (hi),
      .lo         (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and follow it to completion. With poke set, a
   // conflicting start is pulsed in the middle of the calculation.
   task automatic run_op(input string tag, input logic o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] eh,
                         input logic [31:0] el, input bit poke);
      int n;
      int nb;
      int hw_bad;
      op = o; a = av; b = bv; start = 1'b1;
      tick();
      start = 1'b0;
      nb = busy ? 1 : 0;
      n = 0;
      hw_bad = 0;
      while (!done && n < 100) begin
         if (poke && n == 5) begin
            start = 1'b1; op = ~o; a = 32'h1234_5678; b = 32'h0000_0009;
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
         if (busy) nb++;
         if (hilo_write !== done) hw_bad++;
      end
      start = 1'b0;
      check({tag, "_latency"}, n, 33);
      check({tag, "_hi"}, hi, eh);
      check({tag, "_lo"}, lo, el);
      check({tag, "_hilo_write"}, hilo_write, 1'b1);
      check({tag, "_hw_eq_done"}, hw_bad, 0);
      tick();
      check({tag, "_busy_cycles"}, nb, 34);
      check({tag, "_idle_busy"}, busy, 1'b0);
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_hold_lo"}, lo, el);
   endtask

   initial begin
      int n;
      int nd;
      reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_hw", hilo_write, 1'b0);
      check("rst_dz", div_zero, 1'b0);
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);

      run_op("mul_7xm3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op("mul_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
      run_op("mul_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
      run_op("div_m7d2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
      run_op("div_100d7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
      run_op("mul_3x5", 1'b0, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0);

      // Divide by zero: flag only, Hi/Lo untouched.
      op = 1'b1; a = 32'd5; b = 32'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check("dz_flag", div_zero, 1'b1);
      check("dz_busy", busy, 1'b1);
      check("dz_nodone", done, 1'b0);
      tick();
      check("dz_flag_clr", div_zero, 1'b0);
      check("dz_idle", busy, 1'b0);
      check("dz_hi", hi, 32'h0);
      check("dz_lo", lo, 32'd15);
      check("dz_nodone2", done, 1'b0);

      // start held high: operands changed mid-op must not leak in, and a
      // second op with the new operands starts right after completion.
      op = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
      tick();
      a = 32'd6; b = 32'd7;
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      check("hold_latency", n, 33);
      check("hold_lo1", lo, 32'd15);
      tick();
      tick();
      start = 1'b0;
      check("hold_restart", busy, 1'b1);
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      check("hold_done2", done, 1'b1);
      check("hold_hi2", hi, 32'h0);
      check("hold_lo2", lo, 32'd42);
      tick();

      // Reset in the 10th CALC cycle aborts the operation.
      op = 1'b0; a = 32'd7; b = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      check("abort_busy_pre", busy, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      nd = 0;
      repeat (40) begin
         tick();
         if (done) nd++;
      end
      check("abort_nodone", nd, 0);

      run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
